// File: rtl/elementwise_result_packer_pkg.sv
// Shared widths, packer defaults and FSM encoding for the element-wise result packer.
package elementwise_result_packer_pkg;

  localparam int INT8_SIZE       = 8;
  localparam int INT32_SIZE      = 32;
  localparam int PACK_LANES      = 8;
  localparam int PACK_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } pack_state_e;

endpackage

// File: rtl/sync_word_fifo.sv
// Small synchronous word FIFO; the head entry is read straight from the storage registers.
module sync_word_fifo #(
  parameter int WIDTH = 73,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic             head_valid_o,
  output logic             full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign head_data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign head_valid_o = !empty;

endmodule

// File: rtl/elementwise_result_packer.sv
// Packs the int8 result stream little-endian into LANES-byte words with strobes and a
// last flag, counting against a programmed job length and buffering words in a FIFO.
module elementwise_result_packer
  import elementwise_result_packer_pkg::*;
#(
  parameter int LANES      = PACK_LANES,
  parameter int FIFO_DEPTH = PACK_FIFO_DEPTH
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic [INT32_SIZE-1:0]         total_len_i,
  input  logic                          in_valid_i,
  input  logic [INT8_SIZE-1:0]          in_data_i,
  output logic                          in_ready_o,
  output logic                          out_valid_o,
  output logic [LANES*INT8_SIZE-1:0]    out_data_o,
  output logic [LANES-1:0]              out_strb_o,
  output logic                          out_last_o,
  input  logic                          out_ready_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          overflow_o
);

  localparam int WORD_W  = LANES * INT8_SIZE;
  localparam int ENTRY_W = WORD_W + LANES + 1;
  localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;

  pack_state_e           state_q, state_d;
  logic [INT32_SIZE-1:0] remaining_q, remaining_d;
  logic [LANE_W-1:0]     lane_idx_q, lane_idx_d;
  logic [WORD_W-1:0]     data_q, data_d;
  logic [LANES-1:0]      strb_q, strb_d;
  logic                  overflow_q, overflow_d;

  logic [WORD_W-1:0]     data_w;
  logic [LANES-1:0]      strb_w;
  logic                  in_ready;
  logic                  push;
  logic [ENTRY_W-1:0]    push_entry;
  logic [ENTRY_W-1:0]    head_entry;
  logic                  fifo_full;
  logic                  fifo_pop;
  logic                  done;

  // Assembly register with the incoming result merged into the current lane.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic lane_hit;
    assign lane_hit = (lane_idx_q == LANE_W'(gi));
    assign data_w[gi*INT8_SIZE +: INT8_SIZE] = lane_hit ? in_data_i
                                                        : data_q[gi*INT8_SIZE +: INT8_SIZE];
    assign strb_w[gi] = strb_q[gi] | lane_hit;
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    lane_idx_d  = lane_idx_q;
    data_d      = data_q;
    strb_d      = strb_q;
    overflow_d  = overflow_q;
    in_ready    = 1'b0;
    push        = 1'b0;
    push_entry  = '0;
    done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          remaining_d = total_len_i;
          lane_idx_d  = '0;
          data_d      = '0;
          strb_d      = '0;
          overflow_d  = 1'b0;
          state_d     = (total_len_i == '0) ? ST_DONE : ST_PACK;
        end
      end
      ST_PACK: begin
        // Full flag is sampled before any same-cycle pop, so this is conservative.
        in_ready = !fifo_full;
        if (in_valid_i && in_ready) begin
          remaining_d = remaining_q - 1'b1;
          if ((lane_idx_q == LANE_W'(LANES - 1)) || (remaining_q == INT32_SIZE'(1))) begin
            push       = 1'b1;
            push_entry = {remaining_q == INT32_SIZE'(1), strb_w, data_w};
            lane_idx_d = '0;
            data_d     = '0;
            strb_d     = '0;
            if (remaining_q == INT32_SIZE'(1)) begin
              state_d = ST_DRAIN;
            end
          end else begin
            lane_idx_d = lane_idx_q + 1'b1;
            data_d     = data_w;
            strb_d     = strb_w;
          end
        end else if (in_valid_i) begin
          overflow_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (out_valid_o && out_ready_i && out_last_o) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      lane_idx_q  <= '0;
      data_q      <= '0;
      strb_q      <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      lane_idx_q  <= lane_idx_d;
      data_q      <= data_d;
      strb_q      <= strb_d;
      overflow_q  <= overflow_d;
    end
  end

  assign fifo_pop = out_valid_o && out_ready_i;

  sync_word_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_word_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (push),
    .push_data_i  (push_entry),
    .pop_i        (fifo_pop),
    .head_data_o  (head_entry),
    .head_valid_o (out_valid_o),
    .full_o       (fifo_full)
  );

  assign out_last_o = head_entry[ENTRY_W-1];
  assign out_strb_o = head_entry[WORD_W +: LANES];
  assign out_data_o = head_entry[WORD_W-1:0];
  assign in_ready_o = in_ready;
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = done;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_elementwise_result_packer.sv
// Self-checking bench for elementwise_result_packer: randomized jobs compared against a
// byte-queue model that chunks results into little-endian words.
module tb_elementwise_result_packer;

  localparam int ENTRY_W = 73;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] total_len;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic [7:0]  out_strb;
  logic        out_last;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        overflow;

  int total;
  int bad;
  int cyc;
  int start_cyc;
  int done_cnt;
  int done_cyc;
  int last_hs_cyc;
  int feed_idx;
  bit in_acc;
  bit prev_stalled;
  logic [ENTRY_W-1:0] prev_word;
  int stall_viol;

  logic [7:0]         bytes_q[$];
  logic [ENTRY_W-1:0] got_q[$];
  logic [ENTRY_W-1:0] exp_q[$];

  elementwise_result_packer dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .total_len_i (total_len),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_strb_o  (out_strb),
    .out_last_o  (out_last),
    .out_ready_i (out_ready),
    .busy_o      (busy),
    .done_o      (done),
    .overflow_o  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock period: observe settled outputs after inputs are applied, then advance.
  task automatic cycle();
    #1;
    if (out_valid && out_ready) begin
      got_q.push_back({out_last, out_strb, out_data});
      if (out_last) last_hs_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (prev_stalled) begin
      if (out_valid !== 1'b1 || {out_last, out_strb, out_data} !== prev_word) stall_viol++;
    end
    prev_stalled = out_valid && !out_ready;
    prev_word    = {out_last, out_strb, out_data};
    in_acc       = in_valid && in_ready;
    @(negedge clk);
    cyc++;
  endtask

  task automatic gen_bytes(input int n);
    bytes_q.delete();
    for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom));
  endtask

  // Reference: consecutive groups of 8 results, element k in byte k, tail zero-filled.
  task automatic build_model(input int n);
    exp_q.delete();
    for (int w = 0; w * 8 < n; w++) begin
      logic [63:0] d;
      logic [7:0]  s;
      d = '0;
      s = '0;
      for (int k = 0; k < 8; k++) begin
        if (w * 8 + k < n) begin
          d[8*k +: 8] = bytes_q[w*8 + k];
          s[k]        = 1'b1;
        end
      end
      exp_q.push_back({((w + 1) * 8 >= n), s, d});
    end
  endtask

  task automatic start_job(input int len, input bit rdy);
    got_q.delete();
    done_cnt    = 0;
    done_cyc    = -1;
    last_hs_cyc = -1;
    feed_idx    = 0;
    start       = 1'b1;
    total_len   = 32'(len);
    in_valid    = 1'b0;
    out_ready   = rdy;
    start_cyc   = cyc;
    cycle();
    start = 1'b0;
  endtask

  // Feeds results respecting in_ready until done pulses or the cycle budget runs out.
  task automatic feed_until_done(input int len, input bit rnd, input int max_cyc);
    int n;
    n = 0;
    while (done_cnt == 0 && n < max_cyc) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = (feed_idx < len) && in_ready;
      in_data   = (feed_idx < len) ? bytes_q[feed_idx] : 8'h00;
      cycle();
      if (in_acc) feed_idx++;
      n++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (done_cnt == 0) begin
      total++;
      bad++;
      $display("FAIL timeout len=%0d: done not seen after %0d cycles, required done pulse", len, max_cyc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, out_valid, out_data, out_strb, out_last, busy, done, overflow} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h required=0",
               {in_ready, out_valid, out_data, out_strb, out_last, busy, done, overflow});
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("test_reset complete");
  endtask

  task automatic test_full_words();
    bytes_q.delete();
    for (int i = 1; i <= 16; i++) bytes_q.push_back(8'(i));
    build_model(16);
    start_job(16, 1'b1);
    feed_until_done(16, 1'b0, 100);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL full16_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL full16_word%0d got=%h required=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (done_cyc != start_cyc + 18) begin
      bad++;
      $display("FAIL full16_done_latency got=%0d required=%0d", done_cyc - start_cyc, 18);
    end
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL full16_idle_after_done got busy,done=%b required=00", {busy, done});
    end
    $display("test_full_words len=16 words=%0d done_cyc=%0d", got_q.size(), done_cyc - start_cyc);
  endtask

  task automatic test_partial();
    bytes_q.delete();
    for (int i = 1; i <= 11; i++) bytes_q.push_back(8'(-i));
    build_model(11);
    start_job(11, 1'b1);
    feed_until_done(11, 1'b0, 100);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL partial11_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL partial11_word%0d got=%h required=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (done_cyc != last_hs_cyc + 1) begin
      bad++;
      $display("FAIL partial11_done_after_last got=%0d required=%0d", done_cyc, last_hs_cyc + 1);
    end
    $display("test_partial len=11 words=%0d", got_q.size());
  endtask

  task automatic test_zero_len();
    bytes_q.delete();
    start_job(0, 1'b1);
    feed_until_done(0, 1'b0, 20);
    total++;
    if (done_cyc != start_cyc + 1) begin
      bad++;
      $display("FAIL zero_len_done got=%0d required=%0d", done_cyc - start_cyc, 1);
    end
    total++;
    if (got_q.size() != 0) begin
      bad++;
      $display("FAIL zero_len_words got=%0d required=0", got_q.size());
    end
    $display("test_zero_len done_cyc=%0d", done_cyc - start_cyc);
  endtask

  task automatic test_backpressure();
    gen_bytes(48);
    build_model(48);
    start_job(48, 1'b0);
    for (int n = 0; n < 60; n++) begin
      out_ready = 1'b0;
      in_valid  = (feed_idx < 48) && in_ready;
      in_data   = (feed_idx < 48) ? bytes_q[feed_idx] : 8'h00;
      cycle();
      if (in_acc) feed_idx++;
    end
    in_valid = 1'b0;
    total++;
    if (feed_idx != 32) begin
      bad++;
      $display("FAIL bp_accepted got=%0d required=32", feed_idx);
    end
    total++;
    if (in_ready !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL bp_full_state got in_ready,overflow=%b required=00", {in_ready, overflow});
    end
    in_valid = 1'b1;
    in_data  = ~bytes_q[32];
    cycle();
    in_valid = 1'b0;
    cycle();
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL bp_overflow got=%b required=1", overflow);
    end
    feed_until_done(48, 1'b0, 300);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL bp_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL bp_word%0d got=%h required=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL bp_overflow_sticky got=%b required=1", overflow);
    end
    $display("test_backpressure len=48 words=%0d overflow=%b", got_q.size(), overflow);
  endtask

  task automatic test_random_stall();
    gen_bytes(40);
    build_model(40);
    stall_viol   = 0;
    prev_stalled = 1'b0;
    start_job(40, 1'($urandom_range(0, 1)));
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL stall_overflow_cleared got=%b required=0", overflow);
    end
    feed_until_done(40, 1'b1, 1000);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL stall_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL stall_word%0d got=%h required=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (stall_viol != 0) begin
      bad++;
      $display("FAIL stall_hold got=%0d changes required=0", stall_viol);
    end
    $display("test_random_stall len=40 words=%0d", got_q.size());
  endtask

  task automatic test_random_jobs();
    for (int j = 0; j < 6; j++) begin
      int len;
      len = $urandom_range(1, 30);
      gen_bytes(len);
      build_model(len);
      start_job(len, 1'b1);
      feed_until_done(len, 1'b1, 1000);
      total++;
      if (got_q.size() != exp_q.size()) begin
        bad++;
        $display("FAIL rand%0d_count got=%0d required=%0d", j, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL rand%0d_word%0d got=%h required=%h", j, i, got_q[i], exp_q[i]);
        end
      end
      total++;
      if (done_cyc != last_hs_cyc + 1) begin
        bad++;
        $display("FAIL rand%0d_done_after_last got=%0d required=%0d", j, done_cyc, last_hs_cyc + 1);
      end
      $display("test_random_jobs job=%0d len=%0d words=%0d", j, len, got_q.size());
    end
  endtask

  task automatic test_async_reset();
    gen_bytes(16);
    start_job(16, 1'b0);
    for (int n = 0; n < 40 && feed_idx < 12; n++) begin
      out_ready = 1'b0;
      in_valid  = in_ready;
      in_data   = bytes_q[feed_idx];
      cycle();
      if (in_acc) feed_idx++;
    end
    in_valid = 1'b0;
    total++;
    if ({out_valid, busy} !== 2'b11) begin
      bad++;
      $display("FAIL areset_pre got out_valid,busy=%b required=11", {out_valid, busy});
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, out_data, out_strb, out_last, busy, done, overflow} !== '0) begin
      bad++;
      $display("FAIL areset_outputs got=%h required=0",
               {in_ready, out_valid, out_data, out_strb, out_last, busy, done, overflow});
    end
    @(negedge clk);
    rst_n        = 1'b1;
    prev_stalled = 1'b0;
    @(negedge clk);
    gen_bytes(8);
    build_model(8);
    start_job(8, 1'b1);
    feed_until_done(8, 1'b0, 100);
    total++;
    if (got_q.size() != 1) begin
      bad++;
      $display("FAIL areset_restart_count got=%0d required=1", got_q.size());
    end
    if (got_q.size() > 0) begin
      total++;
      if (got_q[0] !== exp_q[0]) begin
        bad++;
        $display("FAIL areset_restart_word got=%h required=%h", got_q[0], exp_q[0]);
      end
    end
    $display("test_async_reset restart words=%0d", got_q.size());
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    cyc          = 0;
    stall_viol   = 0;
    prev_stalled = 1'b0;
    prev_word    = '0;
    rst_n        = 1'b0;
    start        = 1'b0;
    total_len    = '0;
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b0;
    test_reset();
    test_full_words();
    test_partial();
    test_zero_len();
    test_backpressure();
    test_random_stall();
    test_random_jobs();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
